icb_dma_master: RTL and testbench

- ICB initiator that copies a block of 32-bit words from a source address to a destination address, one read then one write per word.
- Sits between the CPU-side control registers and the accelerator's ICB slave port; it drives the command channel and consumes the response channel.
- At most one transaction is outstanding at any time.
- Used to preload accelerator SRAM or drain results without CPU load/store loops.

---
 rtl/icb_dma_master_if.sv | 23 ++
 rtl/icb_dma_master.sv | 124 ++++++++++++
 tb/tb_icb_dma_master.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/icb_dma_master_if.sv
// ICB command/response channel bundle shared by the DMA initiator and its slave.
interface icb_dma_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_read;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/icb_dma_master.sv
// ICB DMA initiator: copies len 32-bit words from src to dst, one read then one
// write per word, with at most one transaction outstanding.
module icb_dma_master #(
  parameter int          LEN_W     = 13,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [31:0]         src_addr,
  input  logic [31:0]         dst_addr,
  input  logic [LEN_W-1:0]    len,
  output logic                busy,
  output logic                done,
  output logic                err,
  icb_dma_master_if.master    icb
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_CMD = 3'd1;
  localparam logic [2:0] S_RD_RSP = 3'd2;
  localparam logic [2:0] S_WR_CMD = 3'd3;
  localparam logic [2:0] S_WR_RSP = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;

  logic [2:0]       state;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [31:0]      data_q;
  logic [LEN_W-1:0] remaining;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      data_q    <= '0;
      remaining <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_q     <= src_addr;
            dst_q     <= dst_addr;
            remaining <= len;
            err       <= 1'b0;
            state     <= (len == '0) ? S_FIN : S_RD_CMD;
          end
        end
        S_RD_CMD: begin
          if (icb.cmd_ready) state <= S_RD_RSP;
        end
        S_RD_RSP: begin
          if (icb.rsp_valid) begin
            if (icb.rsp_err) begin
              err   <= 1'b1;
              state <= S_FIN;
            end else begin
              data_q <= icb.rsp_rdata;
              state  <= S_WR_CMD;
            end
          end
        end
        S_WR_CMD: begin
          if (icb.cmd_ready) state <= S_WR_RSP;
        end
        S_WR_RSP: begin
          if (icb.rsp_valid) begin
            if (icb.rsp_err) begin
              err   <= 1'b1;
              state <= S_FIN;
            end else begin
              src_q     <= src_q + ADDR_STEP;
              dst_q     <= dst_q + ADDR_STEP;
              remaining <= remaining - LEN_W'(1);
              state     <= (remaining == LEN_W'(1)) ? S_FIN : S_RD_CMD;
            end
          end
        end
        S_FIN: begin
          // done is registered, so it lands the cycle after FIN as busy drops.
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus outputs are decoded from state and registers only, never from inputs.
  // NOTE: every output gets a default first so no path through the case
  // leaves a value unassigned and infers a latch.
  always_comb begin
    icb.cmd_valid = 1'b0;
    icb.cmd_read  = 1'b0;
    icb.cmd_addr  = '0;
    icb.cmd_wdata = '0;
    icb.cmd_wmask = 4'h0;
    icb.rsp_ready = 1'b0;
    case (state)
      S_RD_CMD: begin
        icb.cmd_valid = 1'b1;
        icb.cmd_read  = 1'b1;
        icb.cmd_addr  = src_q;
      end
      S_WR_CMD: begin
        icb.cmd_valid = 1'b1;
        icb.cmd_addr  = dst_q;
        icb.cmd_wdata = data_q;
        icb.cmd_wmask = 4'hF;
      end
      S_RD_RSP, S_WR_RSP: icb.rsp_ready = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_icb_dma_master.sv
// Self-checking bench for icb_dma_master: vector table of transfers, a slave
// model with back-pressure/error injection, and a command scoreboard.
module tb_icb_dma_master;
  localparam int LEN_W = 13;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic             err;

  icb_dma_master_if icb();

  icb_dma_master #(.LEN_W(LEN_W), .ADDR_STEP(32'd4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .icb      (icb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } cmd_t;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    logic [31:0] data_base;
    int          err_idx;
    int          bp;
    int          lat;
    logic        exp_err;
  } vec_t;

  cmd_t        exp_q[$];
  logic [31:0] rdata_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cur_vec = -1;
  int          bp_max = 0;
  int          err_read_idx = -1;
  int          read_cnt = 0;
  bit          hold_off = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL vec%0d %s: got %h expected %h", cur_vec, name, act, exp);
    end
  endtask

  // Slave model: acts just after the falling edge so the DUT outputs are
  // settled and the bench's own falling-edge drives are already visible.
  initial begin : slave
    bit   cmd_fire_d, cmd_rd_d, rsp_fire_d, armed, stalled;
    int   stall;
    cmd_t last;
    cmd_t e;
    icb.cmd_ready = 1'b0;
    icb.rsp_valid = 1'b0;
    icb.rsp_rdata = '0;
    icb.rsp_err   = 1'b0;
    cmd_fire_d = 0; cmd_rd_d = 0; rsp_fire_d = 0; armed = 0; stalled = 0; stall = 0;
    last = '{1'b0, 32'h0, 32'h0, 4'h0};
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        icb.rsp_valid = 1'b0;
        icb.rsp_err   = 1'b0;
        icb.cmd_ready = 1'b0;
        cmd_fire_d = 0; rsp_fire_d = 0; armed = 0; stalled = 0;
        continue;
      end
      if (rsp_fire_d) begin
        icb.rsp_valid = 1'b0;
        icb.rsp_err   = 1'b0;
      end
      if (cmd_fire_d) begin
        icb.rsp_valid = 1'b1;
        if (cmd_rd_d) begin
          icb.rsp_rdata = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'hDEAD_BEEF;
          icb.rsp_err   = (read_cnt == err_read_idx);
          read_cnt++;
        end else begin
          icb.rsp_rdata = $urandom;
          icb.rsp_err   = 1'b0;
        end
      end
      if (stalled) begin
        check("cmd_hold_valid", icb.cmd_valid, 1);
        check("cmd_hold_read",  icb.cmd_read, last.rd);
        check("cmd_hold_addr",  icb.cmd_addr, last.addr);
        check("cmd_hold_wdata", icb.cmd_wdata, last.wdata);
      end
      if (hold_off && !icb.cmd_read) icb.cmd_ready = 1'b0;
      else if (bp_max == 0) icb.cmd_ready = 1'b1;
      else if (icb.cmd_valid) begin
        if (!armed) begin
          stall = $urandom_range(0, bp_max);
          armed = 1;
        end
        if (stall == 0) icb.cmd_ready = 1'b1;
        else begin
          icb.cmd_ready = 1'b0;
          stall--;
        end
      end else icb.cmd_ready = 1'b0;
      cmd_fire_d = icb.cmd_valid && icb.cmd_ready;
      cmd_rd_d   = icb.cmd_read;
      stalled    = icb.cmd_valid && !icb.cmd_ready;
      last       = '{icb.cmd_read, icb.cmd_addr, icb.cmd_wdata, icb.cmd_wmask};
      if (cmd_fire_d) begin
        armed = 0;
        check("cmd_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("cmd_read",  icb.cmd_read, e.rd);
          check("cmd_addr",  icb.cmd_addr, e.addr);
          check("cmd_wdata", icb.cmd_wdata, e.wdata);
          check("cmd_wmask", icb.cmd_wmask, e.wmask);
        end
      end
      rsp_fire_d = icb.rsp_valid && icb.rsp_ready;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_cmd_valid"}, icb.cmd_valid, 0);
    check({tag, "_cmd_read"}, icb.cmd_read, 0);
    check({tag, "_cmd_addr"}, icb.cmd_addr, 0);
    check({tag, "_cmd_wdata"}, icb.cmd_wdata, 0);
    check({tag, "_cmd_wmask"}, icb.cmd_wmask, 0);
    check({tag, "_rsp_ready"}, icb.rsp_ready, 0);
  endtask

  task automatic push_expect(input vec_t v);
    for (int i = 0; i < v.len; i++) begin
      logic [31:0] d;
      d = v.data_base + 32'(i);
      exp_q.push_back('{1'b1, v.src + 32'(i * 4), 32'h0, 4'h0});
      rdata_q.push_back(d);
      if (i == v.err_idx) break;
      exp_q.push_back('{1'b0, v.dst + 32'(i * 4), d, 4'hF});
    end
  endtask

  task automatic pulse_start(input vec_t v);
    @(negedge clk);
    start    = 1'b1;
    src_addr = v.src;
    dst_addr = v.dst;
    len      = LEN_W'(v.len);
    @(negedge clk);
    start    = 1'b0;
    src_addr = $urandom;
    dst_addr = $urandom;
    len      = LEN_W'($urandom);
  endtask

  task automatic run_xfer(input vec_t v);
    int cyc;
    bit seen;
    bp_max = v.bp;
    err_read_idx = v.err_idx;
    read_cnt = 0;
    push_expect(v);
    pulse_start(v);
    cyc = 1;
    check("busy_after_start", busy, 1);
    check("err_cleared_on_start", err, 0);
    seen = 0;
    while (cyc < 400 && !seen) begin
      if (done) seen = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("done_seen", 32'(seen), 1);
    if (v.lat != 0) check("start_to_done", cyc, v.lat);
    check("busy_at_done", busy, 0);
    check("err_at_done", err, v.exp_err);
    check("cmds_outstanding", exp_q.size(), 0);
    @(negedge clk);
    check("done_single_cycle", done, 0);
    exp_q.delete();
    rdata_q.delete();
  endtask

  initial begin : main
    vec_t vecs[7];
    vec_t rv;
    int   n;
    bit   any_done;
    vecs[0] = '{32'h0000_1000, 32'h0000_2008, 3, 32'h0000_00A0, -1, 0, 14, 1'b0};
    vecs[1] = '{32'h0000_3000, 32'h0000_4000, 4, 32'h1234_5600, -1, 5, 0,  1'b0};
    vecs[2] = '{32'h0000_5000, 32'h0000_6000, 0, 32'h0,         -1, 0, 2,  1'b0};
    vecs[3] = '{32'h0000_7000, 32'h0000_8000, 5, 32'hCAFE_0000,  1, 0, 8,  1'b1};
    vecs[4] = '{32'h0000_9000, 32'h0000_A000, 2, 32'h0BAD_0000, -1, 0, 10, 1'b0};
    vecs[5] = '{32'hFFFF_FFFC, 32'h0000_B000, 2, 32'h7700_0000, -1, 0, 10, 1'b0};
    vecs[6] = '{32'h0000_0100, 32'hFFFF_FFF8, 3, 32'h3300_0000, -1, 3, 0,  1'b0};

    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      cur_vec = i;
      run_xfer(vecs[i]);
    end

    // Reset while a write command is stalled: outputs clear, no done pulse.
    cur_vec = 100;
    rv = '{32'h0000_C000, 32'h0000_D000, 3, 32'h0000_0055, -1, 0, 0, 1'b0};
    bp_max = 0; err_read_idx = -1; read_cnt = 0; hold_off = 1'b1;
    push_expect(rv);
    pulse_start(rv);
    n = 0;
    while (n < 50 && !(icb.cmd_valid && !icb.cmd_read)) begin
      @(negedge clk);
      n++;
    end
    check("reached_wr_cmd", 32'(n < 50), 1);
    check("wr_cmd_wdata", icb.cmd_wdata, 32'h0000_0055);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b0;
    hold_off = 1'b0;
    exp_q.delete();
    rdata_q.delete();
    any_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) any_done = 1;
    end
    check("no_activity_after_reset", 32'(any_done), 0);

    cur_vec = 101;
    rv = '{32'h0000_E000, 32'h0000_F004, 2, 32'h0000_9900, -1, 0, 10, 1'b0};
    run_xfer(rv);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
